alu4_arbiter: RTL and testbench

ALU4_ARBITER -- requirements
Module: alu4_arbiter

---
 rtl/alu4_arbiter_pkg.sv | 18 +
 rtl/alu4_arbiter_rr_arb2.sv | 19 +
 rtl/alu4_arbiter.sv | 124 ++++++++++++
 tb/tb_alu4_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu4_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM states,
// default opcode width and bit positions inside the {c,n,z,v} flag nibble.
package alu4_arbiter_pkg;

  localparam int OPW_DEFAULT = 3;

  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu4_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win
// last time is granted; a lone request is always granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu4_arbiter.sv
// Shares one external combinational 4-bit ALU between two requesters.
// One transaction at a time: IDLE accepts, EXEC samples the ALU, RESP holds the result.
module alu4_arbiter
  import alu4_arbiter_pkg::*;
#(
  parameter int OPW = OPW_DEFAULT
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           req0_valid,
  input  logic [OPW-1:0] req0_op,
  input  logic [3:0]     req0_a,
  input  logic [3:0]     req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [OPW-1:0] req1_op,
  input  logic [3:0]     req1_a,
  input  logic [3:0]     req1_b,
  output logic           req1_ready,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [3:0]     rsp_result,
  output logic [3:0]     rsp_flags,
  output logic [OPW-1:0] alu_op,
  output logic [3:0]     alu_a,
  output logic [3:0]     alu_b,
  input  logic [3:0]     alu_result,
  input  logic [3:0]     alu_flags,
  output logic           busy
);

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic           owner_q, owner_d;
  logic [OPW-1:0] op_q, op_d;
  logic [3:0]     a_q, a_d;
  logic [3:0]     b_q, b_d;
  logic [3:0]     result_q, result_d;
  logic [3:0]     flags_q, flags_d;

  logic [1:0]     gnt;
  logic           accept;
  logic           rsp_hs;

  rr_arb2 u_rr_arb2 (
    .req  ({req1_valid, req0_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

  // Ready is offered only while idle, and only to the arbitration winner.
  assign req0_ready = (state_q == ST_IDLE) && gnt[0];
  assign req1_ready = (state_q == ST_IDLE) && gnt[1];
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid = (state_q == ST_RESP) &&  owner_q;
  assign rsp_hs     = owner_q ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flags_d  = flags_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXEC;
          last_d  = gnt[1];
          owner_d = gnt[1];
          op_d    = gnt[1] ? req1_op : req0_op;
          a_d     = gnt[1] ? req1_a  : req0_a;
          b_d     = gnt[1] ? req1_b  : req0_b;
        end
      end
      ST_EXEC: begin
        state_d  = ST_RESP;
        result_d = alu_result;
        flags_d  = alu_flags;
      end
      ST_RESP: begin
        if (rsp_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu4_arbiter.sv
// Scoreboard bench for alu4_arbiter: directed transactions push hand-computed
// responses; a monitor pops them on every response handshake.
module tb_alu4_arbiter;
  import alu4_arbiter_pkg::*;

  localparam int OPW = 3;
  localparam logic [OPW-1:0] OP_ADD = 3'd0;
  localparam logic [OPW-1:0] OP_AND = 3'd2;
  localparam logic [OPW-1:0] OP_XOR = 3'd4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           req0_valid, req1_valid, req0_ready, req1_ready;
  logic [OPW-1:0] req0_op, req1_op, alu_op;
  logic [3:0]     req0_a, req0_b, req1_a, req1_b;
  logic           rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [3:0]     rsp_result, rsp_flags, alu_a, alu_b, alu_result, alu_flags;
  logic           busy;

  typedef struct packed {
    logic       owner;
    logic [3:0] res;
    logic [3:0] flg;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu4_arbiter #(.OPW(OPW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(busy)
  );

  // External ALU: ADD / AND / XOR with {c,n,z,v} flags.
  logic [4:0] sum5;
  always_comb begin
    sum5       = {1'b0, alu_a} + {1'b0, alu_b};
    alu_result = 4'h0;
    alu_flags  = 4'h0;
    case (alu_op)
      OP_ADD: begin
        alu_result        = sum5[3:0];
        alu_flags[FLAG_C] = sum5[4];
        alu_flags[FLAG_V] = (alu_a[3] == alu_b[3]) && (sum5[3] != alu_a[3]);
      end
      OP_AND:  alu_result = alu_a & alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      default: alu_result = 4'h0;
    endcase
    alu_flags[FLAG_N] = alu_result[3];
    alu_flags[FLAG_Z] = (alu_result == 4'h0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int idx, input int budget);
    int cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      if ((idx == 0) ? rsp0_valid : rsp1_valid) break;
      cyc++;
    end
    n_cmp++;
    if (cyc >= budget) begin
      n_err++;
      $display("FAIL rsp%0d_timeout: no valid within %0d cycles", idx, budget);
    end
  endtask

  // Monitor: exclusivity every cycle, scoreboard pop on every response handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rsp0_valid || rsp1_valid) check("rsp_exclusive", rsp0_valid & rsp1_valid, 0);
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rsp: owner %0d result 0x%0h with empty scoreboard",
                   rsp1_valid, rsp_result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_owner",  rsp1_valid, e.owner);
          check("rsp_result", rsp_result, e.res);
          check("rsp_flags",  rsp_flags,  e.flg);
        end
      end
    end
  end

  initial begin
    int   grants;
    logic g;
    reset_n = 1'b0;
    req0_valid = 0; req0_op = '0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = '0; req1_a = 0; req1_b = 0;
    rsp0_ready = 1; rsp1_ready = 1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    check("rst_alu", {alu_op, alu_a, alu_b}, 0);
    check("rst_rsp_data", {rsp_result, rsp_flags}, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single request: ready in T, response in T+2
    sb.push_back('{1'b0, 4'h7, 4'b0000});
    req0_valid = 1; req0_op = OP_ADD; req0_a = 4'h3; req0_b = 4'h4;
    @(negedge clk);
    check("t1_ready_T", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 0;
    @(negedge clk);
    check("t1_exec_busy", busy, 1);
    check("t1_exec_alu", {alu_op, alu_a, alu_b}, {OP_ADD, 4'h3, 4'h4});
    check("t1_rsp_T1", rsp0_valid, 0);
    @(negedge clk);
    check("t1_rsp_T2", {rsp0_valid, rsp1_valid}, 2'b10);
    tick();
    @(negedge clk);
    check("t1_idle", busy, 0);

    // Fresh reset, then both requesters continuously valid: grants 0,1,0
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sb.push_back('{1'b0, 4'h8, 4'b0101});
    sb.push_back('{1'b1, 4'h4, 4'b0000});
    sb.push_back('{1'b0, 4'h8, 4'b0101});
    req0_valid = 1; req0_op = OP_ADD; req0_a = 4'h7; req0_b = 4'h1;
    req1_valid = 1; req1_op = OP_AND; req1_a = 4'hC; req1_b = 4'h5;
    grants = 0;
    for (int c = 0; c < 40 && grants < 3; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        check($sformatf("t2_grant%0d", grants), g, (grants == 1) ? 1 : 0);
        grants++;
      end
    end
    check("t2_grant_count", grants, 3);
    tick();
    req0_valid = 0; req1_valid = 0;
    repeat (4) tick();

    // Requester 1 stalls in RESP; requester 0 waits; non-owner ready high is ignored
    sb.push_back('{1'b1, 4'hA, 4'b0100});
    sb.push_back('{1'b0, 4'h0, 4'b0010});
    rsp1_ready = 0; rsp0_ready = 1;
    req1_valid = 1; req1_op = OP_XOR; req1_a = 4'h9; req1_b = 4'h3;
    req0_valid = 1; req0_op = OP_XOR; req0_a = 4'hA; req0_b = 4'hA;
    @(negedge clk);
    check("t3_tie_to_1", {req0_ready, req1_ready}, 2'b01);
    tick();
    req1_valid = 0;
    wait_rsp(1, 5);
    for (int c = 0; c < 5; c++) begin
      check("t3_stall_valid", {rsp0_valid, rsp1_valid}, 2'b01);
      check("t3_stall_result", rsp_result, 4'hA);
      check("t3_stall_ready", {req0_ready, req1_ready}, 2'b00);
      check("t3_stall_busy", busy, 1);
      tick();
      rsp0_ready = c[0];
      @(negedge clk);
    end
    rsp0_ready = 1;
    tick();
    rsp1_ready = 1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("t3_idle_after_release", busy, 0);
    check("t3_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    wait_rsp(0, 5);
    repeat (2) tick();

    // Carry and zero flags on wrap-around
    sb.push_back('{1'b0, 4'h0, 4'b1010});
    req0_valid = 1; req0_op = OP_ADD; req0_a = 4'hF; req0_b = 4'h1;
    @(negedge clk);
    tick();
    req0_valid = 0;
    wait_rsp(0, 5);
    repeat (2) tick();

    // Reset during EXEC discards the transaction
    req0_valid = 1; req0_op = OP_ADD; req0_a = 4'h3; req0_b = 4'h4;
    @(negedge clk);
    tick();
    req0_valid = 0;
    @(negedge clk);
    check("t5_in_exec", busy, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_alu", {alu_op, alu_a, alu_b}, 0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t5_no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
    end
    sb.push_back('{1'b0, 4'h9, 4'b0100});
    tick();
    req0_valid = 1; req0_op = OP_AND; req0_a = 4'hF; req0_b = 4'h9;
    req1_valid = 1; req1_op = OP_XOR; req1_a = 4'h1; req1_b = 4'h2;
    @(negedge clk);
    check("t5_tie_to_0", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 0; req1_valid = 0;
    wait_rsp(0, 5);
    repeat (3) tick();

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
